// File: rtl/conv_2_div_pkg.sv
// Shared types and constants for the conv_2 sequential signed divider.
package conv_2_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DIVIDEND_W_DEF = 24;
    localparam int DIVISOR_W_DEF  = 8;
    localparam int QUOT_W_DEF     = 16;

    localparam logic [QUOT_W_DEF-1:0] QMAX = 16'h7FFF;
    localparam logic [QUOT_W_DEF-1:0] QMIN = 16'h8000;

    localparam int CNT_W = $clog2(DIVIDEND_W_DEF);

endpackage

// File: rtl/conv_2_div_sat_fix.sv
// Sign application and quotient saturation for the conv_2 divider result.
module conv_2_div_sat_fix
    import conv_2_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF,
    parameter int QUOT_W     = QUOT_W_DEF
) (
    input  logic [DIVIDEND_W-1:0]      q_mag,
    input  logic [DIVISOR_W-1:0]       r_mag,
    input  logic                       q_neg,
    input  logic                       r_neg,
    output logic signed [QUOT_W-1:0]   quot,
    output logic signed [DIVISOR_W-1:0] rem,
    output logic                       ovf
);

    // Largest magnitudes representable as positive / negative quotients.
    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((64'd1 << (QUOT_W-1)) - 64'd1);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(64'd1 << (QUOT_W-1));

    logic [DIVIDEND_W-1:0] q_negated;
    logic [DIVISOR_W-1:0]  r_negated;

    always_comb begin
        q_negated = ~q_mag + 1'b1;
        r_negated = ~r_mag + 1'b1;
        quot      = '0;
        ovf       = 1'b0;
        if (q_neg) begin
            if (q_mag > NEG_LIM) begin
                quot = QUOT_W'(QMIN);
                ovf  = 1'b1;
            end else begin
                quot = q_negated[QUOT_W-1:0];
            end
        end else begin
            if (q_mag > POS_LIM) begin
                quot = QUOT_W'(QMAX);
                ovf  = 1'b1;
            end else begin
                quot = q_mag[QUOT_W-1:0];
            end
        end
        rem = r_neg ? r_negated : r_mag;
    end

endmodule

// File: rtl/conv_2_div_seq.sv
// Restoring signed divider (one quotient bit per cycle) with valid/ready handshakes.
// Build option: CONV_2_DIV_BYPASS_EN lets a new operand pair enter while the result drains.
module conv_2_div_seq
    import conv_2_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF,
    parameter int QUOT_W     = QUOT_W_DEF
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DIVIDEND_W-1:0] din0,
    input  logic signed [DIVISOR_W-1:0]  din1,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [QUOT_W-1:0]    quot,
    output logic signed [DIVISOR_W-1:0] rem,
    output logic                        div_zero,
    output logic                        ovf
);

    state_e                      state_q, state_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic [DIVIDEND_W-1:0]       dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]        dvs_q, dvs_d;
    logic [DIVISOR_W:0]          pr_q, pr_d;
    logic [DIVIDEND_W-1:0]       qmag_q, qmag_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        q_neg_q, q_neg_d;
    logic                        r_neg_q, r_neg_d;
    logic signed [QUOT_W-1:0]    quot_q, quot_d;
    logic signed [DIVISOR_W-1:0] rem_q, rem_d;
    logic                        div_zero_q, div_zero_d;
    logic                        ovf_q, ovf_d;

    logic                        accept;
    logic [DIVIDEND_W-1:0]       din0_abs;
    logic [DIVISOR_W-1:0]        din1_abs;
    logic [DIVISOR_W:0]          pr_shift, pr_trial;
    logic                        step_ge;
    logic signed [QUOT_W-1:0]    fix_quot;
    logic signed [DIVISOR_W-1:0] fix_rem;
    logic                        fix_ovf;

`ifdef CONV_2_DIV_BYPASS_EN
    assign in_ready = in_ready_q || ((state_q == DONE) && out_ready);
`else
    assign in_ready = in_ready_q;
`endif
    assign accept = in_valid && in_ready;

    conv_2_div_sat_fix #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .QUOT_W     (QUOT_W)
    ) u_sat_fix (
        .q_mag (qmag_q),
        .r_mag (pr_q[DIVISOR_W-1:0]),
        .q_neg (q_neg_q),
        .r_neg (r_neg_q),
        .quot  (fix_quot),
        .rem   (fix_rem),
        .ovf   (fix_ovf)
    );

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        pr_d       = pr_q;
        qmag_d     = qmag_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        din0_abs = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;
        din1_abs = din1[DIVISOR_W-1]  ? (~din1 + 1'b1) : din1;
        pr_shift = {pr_q[DIVISOR_W-1:0], dvd_q[cnt_q]};
        pr_trial = pr_shift - {1'b0, dvs_q};
        step_ge  = (pr_shift >= {1'b0, dvs_q});

        case (state_q)
            CALC: begin
                pr_d   = step_ge ? pr_trial : pr_shift;
                qmag_d = {qmag_q[DIVIDEND_W-2:0], step_ge};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                quot_d  = fix_quot;
                rem_d   = fix_rem;
                ovf_d   = fix_ovf;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accept is only possible in IDLE, or in DONE when the bypass is built in.
        if (accept) begin
            dvd_d      = din0_abs;
            dvs_d      = din1_abs;
            pr_d       = '0;
            qmag_d     = '0;
            cnt_d      = CNT_W'(DIVIDEND_W - 1);
            q_neg_d    = din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
            r_neg_d    = din0[DIVIDEND_W-1];
            div_zero_d = (din1 == '0);
            ovf_d      = 1'b0;
            if (din1 == '0) begin
                quot_d  = din0[DIVIDEND_W-1] ? QUOT_W'(QMIN) : QUOT_W'(QMAX);
                rem_d   = din0[DIVISOR_W-1:0];
                state_d = DONE;
            end else begin
                state_d = CALC;
            end
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            pr_q        <= '0;
            qmag_q      <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            pr_q        <= pr_d;
            qmag_q      <= qmag_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_conv_2_div_seq.sv
// Directed-vector bench for conv_2_div_seq; expectations are hand-computed C truncating division.
module tb_conv_2_div_seq;

    logic               ap_clk;
    logic               ap_rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [23:0] din0;
    logic signed [7:0]  din1;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] quot;
    logic signed [7:0]  rem;
    logic               div_zero;
    logic               ovf;

    int n_cmp = 0;
    int n_err = 0;

    conv_2_div_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Offer operands, wait for the accept edge, then count cycles until out_valid.
    // lat = k means out_valid is first seen in cycle accept+k; -1 means it never came.
    task automatic run_div(input logic signed [23:0] a, input logic signed [7:0] b, output int lat);
        int w;
        lat = -1;
        @(negedge ap_clk);
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge ap_clk);
            w++;
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge ap_clk);
        end
    endtask

    task automatic drain_out();
        out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        repeat (3) @(negedge ap_clk);
        n_cmp++;
        if ({in_ready, out_valid, quot, rem, div_zero, ovf} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b q=%0d r=%0d dz=%b ovf=%b, expected all 0",
                     in_ready, out_valid, quot, rem, div_zero, ovf);
        end
        ap_rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b expected 0 before first edge", in_ready);
        end
        @(negedge ap_clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_rise: got %b expected 1 one edge after release", in_ready);
        end
    endtask

    task automatic test_signs();
        int ta[5] = '{1000, -1000, 1000, -1000, 1000};
        int tb[5] = '{7, 7, -7, -7, -128};
        int tq[5] = '{142, -142, -142, 142, -7};
        int tr[5] = '{6, -6, 6, -6, 104};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_div(24'(ta[i]), 8'(tb[i]), lat);
            n_cmp++;
            if (lat !== 26) begin
                n_err++;
                $display("FAIL signs_latency[%0d]: got %0d expected 26", i, lat);
            end
            n_cmp++;
            if (quot !== 16'(tq[i]) || rem !== 8'(tr[i])) begin
                n_err++;
                $display("FAIL signs_result[%0d] %0d/%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                         i, ta[i], tb[i], quot, rem, tq[i], tr[i]);
            end
            n_cmp++;
            if (ovf !== 1'b0 || div_zero !== 1'b0) begin
                n_err++;
                $display("FAIL signs_flags[%0d]: got ovf=%b dz=%b expected 0 0", i, ovf, div_zero);
            end
            drain_out();
        end
    endtask

    task automatic test_saturation();
        int          ta[6] = '{100000, -8388608, -100000, 32767, -32768, 32768};
        int          tb[6] = '{1, -1, 1, 1, 1, -1};
        logic [15:0] tq[6] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000};
        logic        to[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_div(24'(ta[i]), 8'(tb[i]), lat);
            n_cmp++;
            if (lat !== 26 || quot !== tq[i] || rem !== 8'sd0 || ovf !== to[i] || div_zero !== 1'b0) begin
                n_err++;
                $display("FAIL sat[%0d] %0d/%0d: got lat=%0d q=%h r=%0d ovf=%b dz=%b expected lat=26 q=%h r=0 ovf=%b dz=0",
                         i, ta[i], tb[i], lat, quot, rem, ovf, div_zero, tq[i], to[i]);
            end
            drain_out();
        end
    endtask

    task automatic test_div_zero();
        int          ta[2] = '{1234, -5};
        logic [15:0] tq[2] = '{16'h7FFF, 16'h8000};
        logic [7:0]  tr[2] = '{8'hD2, 8'hFB};
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_div(24'(ta[i]), 8'sd0, lat);
            n_cmp++;
            if (lat !== 1) begin
                n_err++;
                $display("FAIL divzero_latency[%0d]: got %0d expected 1", i, lat);
            end
            n_cmp++;
            if (quot !== tq[i] || rem !== tr[i] || div_zero !== 1'b1 || ovf !== 1'b0) begin
                n_err++;
                $display("FAIL divzero_result[%0d]: got q=%h r=%h dz=%b ovf=%b expected q=%h r=%h dz=1 ovf=0",
                         i, quot, rem, div_zero, ovf, tq[i], tr[i]);
            end
            drain_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_div(24'sd5000, -8'sd9, lat);
        n_cmp++;
        if (lat !== 26 || quot !== -16'sd555 || rem !== 8'sd5 || div_zero !== 1'b0) begin
            n_err++;
            $display("FAIL bp_result: got lat=%0d q=%0d r=%0d dz=%b expected lat=26 q=-555 r=5 dz=0",
                     lat, quot, rem, div_zero);
        end
        din0     = 24'sd77;
        din1     = 8'sd3;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge ap_clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== -16'sd555 || rem !== 8'sd5) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b q=%0d r=%0d expected vld=1 rdy=0 q=-555 r=5",
                         c, out_valid, in_ready, quot, rem);
            end
        end
        in_valid = 1'b0;
        drain_out();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int lat;
        @(negedge ap_clk);
        din0     = 24'sd1000;
        din1     = 8'sd7;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge ap_clk);
            w++;
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (4) @(negedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quot, rem, div_zero, ovf} !== 28'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b q=%0d r=%0d dz=%b ovf=%b expected all 0",
                     in_ready, out_valid, quot, rem, div_zero, ovf);
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release: got rdy=%b vld=%b expected 0 0", in_ready, out_valid);
        end
        @(negedge ap_clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_ready: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        run_div(24'sd1000, 8'sd7, lat);
        n_cmp++;
        if (lat !== 26 || quot !== 16'sd142 || rem !== 8'sd6) begin
            n_err++;
            $display("FAIL midreset_rerun: got lat=%0d q=%0d r=%0d expected lat=26 q=142 r=6", lat, quot, rem);
        end
        drain_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        int k;
        logic exp_rdy;
        int   exp_lat;
`ifdef CONV_2_DIV_BYPASS_EN
        exp_rdy = 1'b1;
        exp_lat = 26;
`else
        exp_rdy = 1'b0;
        exp_lat = 27;
`endif
        run_div(24'sd1000, 8'sd7, lat);
        n_cmp++;
        if (lat !== 26 || quot !== 16'sd142) begin
            n_err++;
            $display("FAIL b2b_first: got lat=%0d q=%0d expected lat=26 q=142", lat, quot);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din0      = -24'sd1000;
        din1      = 8'sd7;
        #1;
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL b2b_ready_in_done: got %b expected %b", in_ready, exp_rdy);
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        out_ready = 1'b0;
        lat = -1;
        k = 1;
        while (k <= 60) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            if (!in_ready) in_valid = 1'b0;
            @(negedge ap_clk);
            k++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (lat !== exp_lat || quot !== -16'sd142 || rem !== -8'sd6) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected lat=%0d q=-142 r=-6",
                     lat, quot, rem, exp_lat);
        end
        drain_out();
    endtask

    initial begin
        test_reset();
        test_signs();
        test_saturation();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
